// File: rtl/simd_issue_arbiter_if.sv
// Bundled issue/commit signals between N_SRC SIMD drivers, the arbiter and the ALU pipeline.
// master is the arbiter's view, slave is the surrounding drivers/ALU.
interface simd_issue_arbiter_if #(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned INST_BW = 4,
  parameter int unsigned WID_BW  = 2,
  parameter int unsigned WBW     = 16,
  parameter int unsigned VDIM    = 4
);
  logic [N_SRC-1:0]                     src_rdy;
  logic [N_SRC-1:0]                     src_ack;
  logic [N_SRC-1:0][INST_BW-1:0]        i_pc;
  logic [N_SRC-1:0][WID_BW-1:0]         i_warpid;
  logic [N_SRC-1:0][VDIM-1:0][WBW-1:0]  i_bofs;
  logic [N_SRC-1:0][VDIM-1:0][WBW-1:0]  i_aofs;
  logic                                 dst_rdy;
  logic                                 dst_ack;
  logic [INST_BW-1:0]                   o_pc;
  logic [WID_BW-1:0]                    o_warpid;
  logic [VDIM-1:0][WBW-1:0]             o_bofs;
  logic [VDIM-1:0][WBW-1:0]             o_aofs;
  logic                                 i_commit_dval;
  logic [N_SRC-1:0]                     o_commit_dval;
  logic                                 o_err;

  modport master (
    input  src_rdy, i_pc, i_warpid, i_bofs, i_aofs, dst_ack, i_commit_dval,
    output src_ack, dst_rdy, o_pc, o_warpid, o_bofs, o_aofs, o_commit_dval, o_err
  );

  modport slave (
    output src_rdy, i_pc, i_warpid, i_bofs, i_aofs, dst_ack, i_commit_dval,
    input  src_ack, dst_rdy, o_pc, o_warpid, o_bofs, o_aofs, o_commit_dval, o_err
  );
endinterface

// File: rtl/simd_issue_arbiter.sv
// Round-robin issue arbiter sharing one SIMD ALU among N_SRC drivers, with an in-order
// source-id FIFO that routes each ALU commit pulse back to the issuing driver.
module simd_issue_arbiter #(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned INST_BW = 4,
  parameter int unsigned WID_BW  = 2,
  parameter int unsigned WBW     = 16,
  parameter int unsigned VDIM    = 4,
  parameter int unsigned DEPTH   = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  simd_issue_arbiter_if.master bus
);
  localparam int unsigned IdW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                     vld_q, vld_d;
  logic [INST_BW-1:0]       pc_q;
  logic [WID_BW-1:0]        warpid_q;
  logic [VDIM-1:0][WBW-1:0] bofs_q, aofs_q;
  logic [IdW-1:0]           last_q, oid_q;
  logic [IdW-1:0]           fifo_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [N_SRC-1:0]         commit_q, commit_d;
  logic                     err_q, err_d;

  logic           free, room, gnt, gnt_any, push, pop;
  logic [IdW-1:0] gnt_idx;
  logic [IdW:0]   scan;
  logic [CntW:0]  occ;

  assign free = !vld_q || bus.dst_ack;
  assign occ  = {1'b0, cnt_q} + {{CntW{1'b0}}, vld_q};
  assign room = occ < (CntW + 1)'(DEPTH);
  assign gnt  = free && room && gnt_any;
  assign push = bus.dst_ack && vld_q;
  assign pop  = bus.i_commit_dval && (cnt_q != '0);

  // Scan from last+1 upward with wrap; the first requester seen wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int i = 1; i <= int'(N_SRC); i++) begin
      scan = {1'b0, last_q} + (IdW + 1)'(i);
      if (scan >= (IdW + 1)'(N_SRC)) scan = scan - (IdW + 1)'(N_SRC);
      if (!gnt_any && bus.src_rdy[scan[IdW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IdW-1:0];
      end
    end
  end

  always_comb begin
    bus.src_ack = '0;
    bus.src_ack[gnt_idx] = gnt && !i_rst;
  end

  always_comb begin
    vld_d = vld_q;
    if (gnt)               vld_d = 1'b1;
    else if (bus.dst_ack)  vld_d = 1'b0;

    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    commit_d = '0;
    if (pop) commit_d[fifo_q[rd_ptr_q]] = 1'b1;

    err_d = err_q || (bus.i_commit_dval && (cnt_q == '0)) || (bus.dst_ack && !vld_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q    <= 1'b0;
      pc_q     <= '0;
      warpid_q <= '0;
      bofs_q   <= '0;
      aofs_q   <= '0;
      last_q   <= IdW'(N_SRC - 1);
      oid_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      commit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      if (gnt) begin
        pc_q     <= bus.i_pc[gnt_idx];
        warpid_q <= bus.i_warpid[gnt_idx];
        bofs_q   <= bus.i_bofs[gnt_idx];
        aofs_q   <= bus.i_aofs[gnt_idx];
        last_q   <= gnt_idx;
        oid_q    <= gnt_idx;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Entries are only read once counted valid, so storage needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= oid_q;
  end

  assign bus.dst_rdy       = vld_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_warpid      = warpid_q;
  assign bus.o_bofs        = bofs_q;
  assign bus.o_aofs        = aofs_q;
  assign bus.o_commit_dval = commit_q;
  assign bus.o_err         = err_q;
endmodule

// File: tb/tb_simd_issue_arbiter.sv
// Self-checking bench for simd_issue_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_simd_issue_arbiter;
  localparam int unsigned N_SRC = 2, INST_BW = 4, WID_BW = 2, WBW = 16, VDIM = 4, DEPTH = 8;
  localparam int unsigned VW = VDIM * WBW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  simd_issue_arbiter_if #(.N_SRC(N_SRC), .INST_BW(INST_BW), .WID_BW(WID_BW), .WBW(WBW),
                          .VDIM(VDIM)) bus ();

  simd_issue_arbiter #(.N_SRC(N_SRC), .INST_BW(INST_BW), .WID_BW(WID_BW), .WBW(WBW),
                       .VDIM(VDIM), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model state: what the output stage holds and which sources are in flight.
  bit                 m_vld;
  logic [INST_BW-1:0] m_pc;
  logic [WID_BW-1:0]  m_wid;
  logic [VW-1:0]      m_bofs, m_aofs;
  int                 m_last, m_oid;
  int                 m_q[$];
  logic [N_SRC-1:0]   m_commit;
  bit                 m_err;

  typedef struct {
    logic [1:0] rdy;
    logic       dack;
    logic       cdv;
    logic [1:0] ack;
    logic       drdy;
    logic [3:0] pc;
    logic [1:0] cmt;
    logic       err;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_pc = '0; m_wid = '0; m_bofs = '0; m_aofs = '0;
    m_last = N_SRC - 1; m_oid = 0; m_q.delete(); m_commit = '0; m_err = 0;
  endtask

  function automatic logic [N_SRC-1:0] model_ack();
    logic [N_SRC-1:0] a;
    a = '0;
    if (!rst && (!m_vld || bus.dst_ack) && (m_q.size() + int'(m_vld) < int'(DEPTH)))
      for (int i = 1; i <= int'(N_SRC); i++)
        if (a == '0 && bus.src_rdy[(m_last + i) % N_SRC]) a[(m_last + i) % N_SRC] = 1'b1;
    return a;
  endfunction

  task automatic model_step(input logic [N_SRC-1:0] a, input logic dack, input logic cdv);
    m_commit = '0;
    if (cdv) begin
      if (m_q.size() > 0) m_commit[m_q.pop_front()] = 1'b1;
      else m_err = 1;
    end
    if (dack) begin
      if (m_vld) m_q.push_back(m_oid);
      else m_err = 1;
    end
    if (a != '0) begin
      for (int k = 0; k < int'(N_SRC); k++)
        if (a[k]) begin
          m_oid = k; m_last = k;
          m_pc = bus.i_pc[k]; m_wid = bus.i_warpid[k];
          m_bofs = bus.i_bofs[k]; m_aofs = bus.i_aofs[k];
        end
      m_vld = 1;
    end else if (dack) begin
      m_vld = 0;
    end
  endtask

  task automatic cmp_all(input logic [N_SRC-1:0] a);
    chk("src_ack", 128'(bus.src_ack), 128'(a));
    chk("dst_rdy", 128'(bus.dst_rdy), 128'(m_vld));
    chk("o_pc", 128'(bus.o_pc), 128'(m_pc));
    chk("o_warpid", 128'(bus.o_warpid), 128'(m_wid));
    chk("o_bofs", 128'(bus.o_bofs), 128'(m_bofs));
    chk("o_aofs", 128'(bus.o_aofs), 128'(m_aofs));
    chk("o_commit_dval", 128'(bus.o_commit_dval), 128'(m_commit));
    chk("o_err", 128'(bus.o_err), 128'(m_err));
  endtask

  task automatic sample(output logic [N_SRC-1:0] a);
    #2;
    a = model_ack();
    cmp_all(a);
  endtask

  task automatic advance(input logic [N_SRC-1:0] a);
    model_step(a, bus.dst_ack, bus.i_commit_dval);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rdy, input logic dack, input logic cdv);
    bus.src_rdy = rdy; bus.dst_ack = dack; bus.i_commit_dval = cdv;
  endtask

  task automatic fixed_payload();
    bus.i_pc[0] = 4'h3;      bus.i_pc[1] = 4'hA;
    bus.i_warpid[0] = 2'd1;  bus.i_warpid[1] = 2'd2;
    bus.i_bofs[0] = VW'(64'h1111_2222_3333_4444);
    bus.i_bofs[1] = VW'(64'h5555_6666_7777_8888);
    bus.i_aofs[0] = VW'(64'h9999_AAAA_BBBB_CCCC);
    bus.i_aofs[1] = VW'(64'hDDDD_EEEE_FFFF_0123);
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    cmp_all('0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N_SRC-1:0] a;
    logic [N_SRC-1:0] hold;
    int n_ack;

    tbl[0]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 4'h0, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 4'h3, 2'b00, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 4'hA, 2'b00, 1'b0};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 4'h3, 2'b00, 1'b0};
    tbl[4]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 4'hA, 2'b00, 1'b0};
    tbl[5]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 4'hA, 2'b00, 1'b0};
    tbl[6]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 4'hA, 2'b01, 1'b0};
    tbl[7]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 4'hA, 2'b10, 1'b0};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 4'hA, 2'b01, 1'b0};
    tbl[9]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 4'hA, 2'b10, 1'b0};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 4'hA, 2'b00, 1'b0};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 4'hA, 2'b00, 1'b1};
    tbl[12] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 4'hA, 2'b00, 1'b1};

    fixed_payload();
    #1;
    do_reset();

    // Alternation, routing order and empty-FIFO commit error.
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].rdy, tbl[r].dack, tbl[r].cdv);
      sample(a);
      chk($sformatf("tbl%0d.src_ack", r), 128'(bus.src_ack), 128'(tbl[r].ack));
      chk($sformatf("tbl%0d.dst_rdy", r), 128'(bus.dst_rdy), 128'(tbl[r].drdy));
      chk($sformatf("tbl%0d.o_pc", r), 128'(bus.o_pc), 128'(tbl[r].pc));
      chk($sformatf("tbl%0d.commit", r), 128'(bus.o_commit_dval), 128'(tbl[r].cmt));
      chk($sformatf("tbl%0d.err", r), 128'(bus.o_err), 128'(tbl[r].err));
      advance(a);
    end

    // Stall: no grants while the ALU holds off, then the other source wins on release.
    do_reset();
    drive(2'b11, 1'b0, 1'b0);
    sample(a); advance(a);
    for (int c = 0; c < 5; c++) begin
      sample(a);
      chk("stall.src_ack", 128'(bus.src_ack), 128'(0));
      chk("stall.o_pc", 128'(bus.o_pc), 128'(4'h3));
      advance(a);
    end
    drive(2'b11, 1'b1, 1'b0);
    sample(a);
    chk("stall.release_ack", 128'(bus.src_ack), 128'(2'b10));
    advance(a);
    drive(2'b00, 1'b1, 1'b0);
    sample(a);
    chk("stall.o_pc_next", 128'(bus.o_pc), 128'(4'hA));
    advance(a);

    // Full: DEPTH acks, then blocked until one commit reopens room a cycle later.
    do_reset();
    drive(2'b01, 1'b1, 1'b0);
    n_ack = 0;
    for (int c = 0; c < 14; c++) begin
      sample(a); n_ack += $countones(bus.src_ack); advance(a);
    end
    chk("full.acks", 128'(n_ack), 128'(DEPTH));
    chk("full.dst_rdy", 128'(bus.dst_rdy), 128'(0));
    drive(2'b01, 1'b1, 1'b1);
    sample(a);
    chk("full.no_bypass", 128'(bus.src_ack), 128'(0));
    advance(a);
    drive(2'b01, 1'b1, 1'b0);
    sample(a);
    chk("full.reopen_ack", 128'(bus.src_ack), 128'(2'b01));
    advance(a);
    n_ack = 0;
    for (int c = 0; c < 4; c++) begin
      sample(a); n_ack += $countones(bus.src_ack); advance(a);
    end
    chk("full.refull_acks", 128'(n_ack), 128'(0));

    // Reset mid-burst with three in flight.
    do_reset();
    drive(2'b11, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      sample(a); advance(a);
    end
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst.src_ack", 128'(bus.src_ack), 128'(0));
    chk("rst.dst_rdy", 128'(bus.dst_rdy), 128'(0));
    chk("rst.o_pc", 128'(bus.o_pc), 128'(0));
    chk("rst.o_bofs", 128'(bus.o_bofs), 128'(0));
    chk("rst.o_commit", 128'(bus.o_commit_dval), 128'(0));
    chk("rst.o_err", 128'(bus.o_err), 128'(0));
    drive(2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(2'b11, 1'b0, 1'b0);
    sample(a);
    chk("rst.first_grant", 128'(bus.src_ack), 128'(2'b01));
    advance(a);
    drive(2'b00, 1'b0, 1'b1);
    sample(a); advance(a);
    drive(2'b00, 1'b0, 1'b0);
    sample(a);
    chk("rst.stale_commit", 128'(bus.o_commit_dval), 128'(0));
    chk("rst.stale_err", 128'(bus.o_err), 128'(1));
    advance(a);

    // Randomized legal traffic against the model.
    do_reset();
    hold = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < int'(N_SRC); k++)
        if (!hold[k] && ($urandom_range(2) == 0)) begin
          hold[k] = 1'b1;
          bus.i_pc[k] = INST_BW'($urandom);
          bus.i_warpid[k] = WID_BW'($urandom);
          bus.i_bofs[k] = VW'({$urandom, $urandom});
          bus.i_aofs[k] = VW'({$urandom, $urandom});
        end
      bus.src_rdy = hold;
      bus.dst_ack = m_vld && ($urandom_range(3) != 0);
      bus.i_commit_dval = (m_q.size() > 0) && ($urandom_range(2) == 0);
      sample(a);
      hold = hold & ~a;
      advance(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/simd_issue_arbiter.md
# simd_issue_arbiter

Round-robin issue arbiter that shares one SIMD ALU pipeline among `N_SRC` SIMD instruction drivers. Each driver offers (pc, warpid, bofs, aofs) on its own rdy/ack channel. The arbiter grants one driver per cycle into a registered output stage feeding the ALU pipeline. It also keeps an in-order FIFO of granted source ids, so that each ALU commit pulse is routed back to the driver that issued the instruction. That routing lets every driver keep its own pending-instruction semaphore and drain detection.

## Interface
- `N_SRC`, 2: number of requesting drivers (≥2).
- `INST_BW`, 4: pc width.
- `WID_BW`, 2: warp id width.
- `WBW`, 16: offset word width.
- `VDIM`, 4: offset vector dimension.
- `DEPTH`, 8: max instructions in flight between issue and commit (power of two).
- `i_clk  in  1`: clock; all state on rising edge.
- `i_rst  in  1`: reset, asynchronous, active-high.
- `src_rdy  in  [N_SRC]`: driver k holds an instruction.
- `src_ack  out  [N_SRC]`: one-hot accept pulse.
- `i_pc  in  [N_SRC][INST_BW]`, `i_warpid  in  [N_SRC][WID_BW]`, `i_bofs`/`i_aofs  in  [N_SRC][VDIM][WBW]`: per-driver payload, valid while `src_rdy[k]`.
- `dst_rdy  out  1`: instruction presented to ALU.
- `dst_ack  in  1`: ALU accepts.
- `o_pc`, `o_warpid`, `o_bofs`, `o_aofs`  out: registered payload.
- `i_commit_dval  in  1`: ALU retired the oldest in-flight instruction.
- `o_commit_dval  out  [N_SRC]`: routed one-hot commit pulse.
- `o_err  out  1`: sticky protocol error.

## Operation
- Handshake: rdy is held by the sender until ack. Ack is a single-cycle pulse and only occurs while rdy is high. Payload must be stable while rdy is high.
- Output stage `vld` register drives `dst_rdy`.
  - `free = !vld || dst_ack`.
  - `occ = fifo_cnt + vld`.
  - `room = occ < DEPTH`.
- Grant: when `free && room` and any `src_rdy`, pick the first requester scanning from `(last+1) mod N_SRC` upward with wrap.
  - Assert that bit of `src_ack` combinationally in the same cycle.
  - Load its payload into the output registers and set `vld`.
  - Record the granted index in `last` and in an internal `oid` register.
- `src_ack` is 0 while `i_rst` is high.
- On `dst_ack` with no new grant, clear `vld`. On `dst_ack` together with a grant, `vld` stays 1 with the new payload (back-to-back, 1 instr/cycle).
- Route FIFO: `DEPTH` entries × `$clog2(N_SRC)` bits.
  - Push `oid` on `dst_ack`.
  - Pop on `i_commit_dval`.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- Commit routing: on `i_commit_dval` with the FIFO non-empty, register a one-hot pulse on `o_commit_dval[head]` for exactly the next cycle.
- Error cases (both set `o_err`, which stays high until reset):
  - `i_commit_dval` with the FIFO empty: no pop, no `o_commit_dval`.
  - `dst_ack` without `dst_rdy`: no push.
- Reset (any time, including mid-transfer) clears:
  - `vld`, all payload registers, `last = N_SRC-1` (so driver 0 has first priority), the FIFO pointers and count, `o_commit_dval`, and `o_err`.
  - In-flight instructions are dropped and are not reported.

## Timing
- Grant latency: `src_ack` is in the same cycle as the qualifying `src_rdy`. `dst_rdy` rises 1 cycle later.
- Throughput: 1 grant/cycle while `dst_ack` is held high and `room` is true.
- Backpressure: when `occ == DEPTH` no grant is made. Room reopens the cycle after the commit pop registers; the current-cycle pop is not bypassed.
- Commit latency: `o_commit_dval` appears 1 cycle after `i_commit_dval`.
- Fairness: a continuously requesting driver waits at most `N_SRC-1` grants.
- Reset values: `dst_rdy=0`, `src_ack=0`, all payload outputs 0, `o_commit_dval=0`, `o_err=0`.

## Test plan
- **Alternation:** N_SRC=2, both rdy continuously, `dst_ack` always 1 → grants 0,1,0,1…; `o_pc` follows each source's pc one cycle after its ack; 1 instr/cycle.
- **Routing:**
  - Stimulus: issue src1, src0, src1 and ack each; then pulse `i_commit_dval` on 3 consecutive cycles.
  - Required response: `o_commit_dval` = 10, 01, 10 on cycles +1, +2, +3.
- **Full:**
  - Stimulus: DEPTH=8, src0 rdy, `dst_ack` always 1, no commits.
  - Required response: exactly 8 acks, then `dst_rdy=0` and `src_ack=0`.
  - Then one `i_commit_dval` → exactly one more grant, issued 1 cycle later.
- **Stall:** `dst_ack=0` for 5 cycles with both rdy → no further `src_ack`; `o_pc` stable; `dst_ack` on cycle 6 → next grant goes to the other source in the same cycle.
- **Error:** `i_commit_dval` with the FIFO empty → `o_err=1` next cycle and held high; no `o_commit_dval`.
- **Reset:** assert `i_rst` mid-burst with 3 in flight → all outputs 0 immediately; after release, first grant goes to src0; later commits do not produce `o_commit_dval` for the dropped instructions and instead set `o_err`.
